// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv sequencing controller: FSM state
// encoding and the rstatus exception writeback constants.
package multdiv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BUSY  = 2'd1;
  localparam state_t ST_DONE  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Exceptions are reported as a write of a cause code to rstatus ($30).
  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [7:0] RSTATUS_MUL = 8'd4;
  localparam logic [7:0] RSTATUS_DIV = 8'd5;

  // Cause code for the operation kind that raised the exception.
  function automatic logic [7:0] rstatus_code(input logic is_div);
    return is_div ? RSTATUS_DIV : RSTATUS_MUL;
  endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle watchdog for the multdiv controller. Counts cycles while i_run is
// high and flags o_timeout in the TIMEOUT-th cycle. The count restarts
// whenever i_run drops or i_clear is pulsed (entry into a new wait state).
// Only instantiated when MULTDIV_WATCHDOG_EN is defined.
module multdiv_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // The first waiting cycle sees count 0, so LIMIT = TIMEOUT-1 fires in the TIMEOUT-th cycle.
  assign o_timeout = i_run & (r_count == LIMIT);

  // Wait-cycle counter, restarted on entry to each wait state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!i_run || i_clear) begin
      r_count <= '0;
    end else if (!o_timeout) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the shared multi-cycle multiplier/divider.
// Accepts mul/div requests from the execute stage, latches operands, issues
// a one-cycle start pulse, stalls the pipeline until the result returns and
// presents a single writeback beat (or an rstatus write on exception).
// Flushes while in flight either discard the pending result (DRAIN) or
// cancel the writeback.
// Optional: define MULTDIV_WATCHDOG_EN to bound the BUSY/DRAIN waits to
// TIMEOUT cycles; a BUSY timeout is reported as an exception writeback.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mul_req,
  input  logic              div_req,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              flush,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_op_a,
  output logic [DATA_W-1:0] md_op_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  output logic              stall,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exc,
  input  logic              wb_ack
);

  state_t             r_state;
  logic [REG_W-1:0]   r_rd;
  logic               r_is_div;

  logic               w_req;
  logic               w_accept;
  logic               w_pulse;
  logic               w_ready;
  logic               w_timeout;

  assign w_req    = mul_req | div_req;
  assign w_accept = (r_state == ST_IDLE) & w_req & ~flush;
  // The multdiv unit cannot answer in the same cycle it is started.
  assign w_pulse  = md_ctrl_mult | md_ctrl_div;
  assign w_ready  = md_ready & ~w_pulse;

`ifdef MULTDIV_WATCHDOG_EN
  logic w_wd_run;
  logic w_wd_clear;

  assign w_wd_run   = (r_state == ST_BUSY) | (r_state == ST_DRAIN);
  // BUSY -> DRAIN is the only direct move between the two wait states.
  assign w_wd_clear = (r_state == ST_BUSY) & flush & ~w_ready;

  multdiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_run     (w_wd_run),
    .i_clear   (w_wd_clear),
    .o_timeout (w_timeout)
  );
`else
  // TIMEOUT has no effect without the watchdog; this always evaluates to 0.
  assign w_timeout = (TIMEOUT < 0);
`endif

  // Pipeline freeze: the only combinational output.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      ST_IDLE:  stall = w_req & ~flush;
      ST_BUSY:  stall = 1'b1;
      ST_DONE:  stall = ~wb_ack;
      ST_DRAIN: stall = w_req & ~flush;
      default:  stall = 1'b0;
    endcase
  end

  // Controller FSM with registered start pulses, operands and writeback beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rd         <= '0;
      r_is_div     <= 1'b0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      md_op_a      <= '0;
      md_op_b      <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exc       <= 1'b0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // mul has priority when both requests are decoded together.
            md_ctrl_mult <= mul_req;
            md_ctrl_div  <= ~mul_req;
            r_is_div     <= ~mul_req;
            md_op_a      <= op_a;
            md_op_b      <= op_b;
            r_rd         <= rd_in;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_ready && flush) begin
            r_state <= ST_IDLE;
          end else if (w_ready) begin
            wb_valid <= 1'b1;
            wb_exc   <= md_exception;
            wb_rd    <= md_exception ? REG_W'(RSTATUS_REG) : r_rd;
            wb_data  <= md_exception ? DATA_W'(rstatus_code(r_is_div)) : md_result;
            r_state  <= ST_DONE;
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end else if (w_timeout) begin
            wb_valid <= 1'b1;
            wb_exc   <= 1'b1;
            wb_rd    <= REG_W'(RSTATUS_REG);
            wb_data  <= DATA_W'(rstatus_code(r_is_div));
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (wb_ack || flush) begin
            wb_valid <= 1'b0;
            wb_exc   <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            r_state  <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // The abandoned operation's result is dropped on arrival.
          if (md_ready || w_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
